// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core constants: register count, execution pipe IDs, pipe latencies
package core_pkg;

  localparam int NUM_REGS  = 32;
  localparam int NUM_PIPES = 4;

  localparam int EXE_PIPE_ID_ALU = 0;
  localparam int EXE_PIPE_ID_LSU = 1;
  localparam int EXE_PIPE_ID_MUL = 2;
  localparam int EXE_PIPE_ID_DIV = 3;

  // A latency of 0 marks a variable-latency pipe whose write-back is arbitrated downstream.
  localparam logic [7:0] LATENCY_ALU = 8'd1;
  localparam logic [7:0] LATENCY_LSU = 8'd2;
  localparam logic [7:0] LATENCY_MUL = 8'd4;
  localparam logic [7:0] LATENCY_VAR = 8'd0;

  // Pipe 0 occupies the least significant byte.
  localparam logic [NUM_PIPES*8-1:0] PIPE_LAT_DEFAULT =
    {LATENCY_VAR, LATENCY_MUL, LATENCY_LSU, LATENCY_ALU};

endpackage

// File: rtl/wb_slot_reservation.sv
// rtl/wb_slot_reservation.sv - shifting table of write-back port usage for fixed-latency pipes
module wb_slot_reservation
  import core_pkg::*;
#(
  parameter int MAX_LAT      = 8,
  parameter int NUM_WB_PORTS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fire,
  input  logic [7:0] lat,
  output logic       slot_full
);

  localparam int CW = $clog2(NUM_WB_PORTS + 1);

  // Slot k (1..MAX_LAT) lives at bits [(k-1)*CW +: CW] and counts write-backs k cycles ahead.
  logic [MAX_LAT*CW-1:0] res;
  logic [MAX_LAT*CW-1:0] res_next;

  // The slot an op of latency lat would write back into is full when every port is taken.
  always_comb begin
    slot_full = 1'b0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (lat == 8'(k)) begin
        slot_full = (res[(k-1)*CW +: CW] == CW'(NUM_WB_PORTS));
      end
    end
  end

  // Age every slot one cycle; a newly issued op lands one slot nearer than its latency.
  always_comb begin
    res_next = res >> CW;
    if (fire) begin
      for (int k = 1; k < MAX_LAT; k++) begin
        if (lat == 8'(k + 1)) begin
          res_next[(k-1)*CW +: CW] = res_next[(k-1)*CW +: CW] + CW'(1);
        end
      end
    end
  end

  // Reservation table register.
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
    end else begin
      res <= res_next;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue-stage hazard tracker (RAW/WAW/WB slot/var pipe); bypass under SCOREBOARD_WB_BYPASS_EN
module issue_scoreboard
  import core_pkg::*;
#(
  parameter int                     NUM_REGS     = core_pkg::NUM_REGS,
  parameter int                     NUM_PIPES    = core_pkg::NUM_PIPES,
  parameter int                     NUM_WB_PORTS = 1,
  parameter int                     MAX_LAT      = 8,
  parameter logic [NUM_PIPES*8-1:0] PIPE_LAT     = core_pkg::PIPE_LAT_DEFAULT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      stall,
  input  logic                                      flush,
  input  logic                                      flush_var,
  input  logic                                      issue_valid,
  input  logic [$clog2(NUM_PIPES)-1:0]              issue_pipe,
  input  logic [$clog2(NUM_REGS)-1:0]               issue_rd,
  input  logic                                      issue_rd_wr,
  input  logic [$clog2(NUM_REGS)-1:0]               issue_rs1,
  input  logic [$clog2(NUM_REGS)-1:0]               issue_rs2,
  input  logic [1:0]                                issue_use_rs,
  output logic                                      issue_ready,
  input  logic [NUM_WB_PORTS-1:0]                   wb_valid,
  input  logic [NUM_WB_PORTS*$clog2(NUM_REGS)-1:0]  wb_rd,
  input  logic [NUM_PIPES-1:0]                      var_done,
  output logic [NUM_PIPES-1:0]                      var_busy,
  output logic [NUM_REGS-1:0]                       pending,
  output logic [NUM_WB_PORTS-1:0]                   fwd_rs1,
  output logic [NUM_WB_PORTS-1:0]                   fwd_rs2
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int PW = $clog2(NUM_PIPES);

  for (genvar p = 0; p < NUM_PIPES; p++) begin : g_lat_chk
    if (int'(PIPE_LAT[p*8 +: 8]) > MAX_LAT) begin : g_bad_lat
      $error("issue_scoreboard: PIPE_LAT entry exceeds MAX_LAT");
    end
  end

  if (NUM_WB_PORTS < 1 || NUM_WB_PORTS > 4) begin : g_bad_ports
    $error("issue_scoreboard: NUM_WB_PORTS must be 1..4");
  end

  logic [7:0]              lat;
  logic                    fire;
  logic                    slot_full;
  logic                    raw;
  logic                    waw;
  logic                    var_conflict;
  logic [NUM_WB_PORTS-1:0] match_rs1;
  logic [NUM_WB_PORTS-1:0] match_rs2;
  logic [NUM_REGS-1:0]     wb_clear;
  logic [NUM_REGS-1:0]     pending_set;

  assign lat = PIPE_LAT[{issue_pipe, 3'b000} +: 8];

`ifdef SCOREBOARD_WB_BYPASS_EN
  // The lowest-index write-back port carrying a source register bypasses it this cycle.
  always_comb begin
    match_rs1 = '0;
    match_rs2 = '0;
    for (int p = NUM_WB_PORTS - 1; p >= 0; p--) begin
      if (wb_valid[p] && wb_rd[p*RW +: RW] == issue_rs1 && issue_rs1 != '0) begin
        match_rs1    = '0;
        match_rs1[p] = 1'b1;
      end
      if (wb_valid[p] && wb_rd[p*RW +: RW] == issue_rs2 && issue_rs2 != '0) begin
        match_rs2    = '0;
        match_rs2[p] = 1'b1;
      end
    end
  end
`else
  assign match_rs1 = '0;
  assign match_rs2 = '0;
`endif

  assign fwd_rs1 = rst ? '0 : match_rs1;
  assign fwd_rs2 = rst ? '0 : match_rs2;

  // Hazard evaluation against the registered state; x0 is never pending so never conflicts.
  always_comb begin
    raw          = (issue_use_rs[0] & pending[issue_rs1] & ~(|match_rs1)) |
                   (issue_use_rs[1] & pending[issue_rs2] & ~(|match_rs2));
    waw          = issue_rd_wr & pending[issue_rd];
    var_conflict = (lat == 8'd0) & var_busy[issue_pipe];
    issue_ready  = ~(raw | waw | slot_full | var_conflict);
    fire         = issue_valid & issue_ready & ~stall & ~flush;
  end

  // Build the clear mask from write-backs and the set mask from an issuing writer.
  always_comb begin
    wb_clear = '0;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        wb_clear[wb_rd[p*RW +: RW]] = 1'b1;
      end
    end
    pending_set = '0;
    if (fire && issue_rd_wr && issue_rd != '0) begin
      pending_set[issue_rd] = 1'b1;
    end
  end

  // Pending-write vector; a same-cycle set overrides a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~wb_clear) | pending_set;
    end
  end

  // Variable-latency pipe busy flags; completion or abort overrides a new issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      var_busy <= '0;
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        if (var_done[p] || flush_var) begin
          var_busy[p] <= 1'b0;
        end else if (fire && lat == 8'd0 && issue_pipe == PW'(p)) begin
          var_busy[p] <= 1'b1;
        end
      end
    end
  end

  wb_slot_reservation #(
    .MAX_LAT      (MAX_LAT),
    .NUM_WB_PORTS (NUM_WB_PORTS)
  ) u_wb_slots (
    .clk       (clk),
    .rst       (rst),
    .fire      (fire),
    .lat       (lat),
    .slot_full (slot_full)
  );

endmodule
